// File: rtl/layer_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : layer_out_serializer
// Description : Captures a parallel layer output vector, replays it one word
//               per cycle and tracks the running argmax of the stream.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_out_serializer #(
  parameter int NUM_NEURON = 2,
  parameter int DATA_W     = 16,
  parameter bit SIGNED     = 1'b1,
  localparam int IDX_W     = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_NEURON-1:0]        in_valid,
  input  logic [NUM_NEURON*DATA_W-1:0] in_data,
  input  logic                         clr_err,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         busy,
  output logic                         done,
  output logic [IDX_W-1:0]             max_idx,
  output logic [DATA_W-1:0]            max_val,
  output logic                         overrun,
  output logic                         mismatch
);

  localparam logic [0:0]       c_idle  = 1'b0;
  localparam logic [0:0]       c_shift = 1'b1;
  localparam logic [IDX_W-1:0] c_last  = IDX_W'(NUM_NEURON - 1);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [IDX_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_buf [NUM_NEURON];
  logic [DATA_W-1:0] r_run_val;
  logic [IDX_W-1:0]  r_run_idx;
  logic              r_done;
  logic [IDX_W-1:0]  r_max_idx;
  logic [DATA_W-1:0] r_max_val;
  logic              r_overrun;
  logic              r_mismatch;

  logic              w_in_shift;
  logic              w_last;
  logic              w_accept;
  logic              w_drop;
  logic              w_mismatch_set;
  logic [DATA_W-1:0] w_word;
  logic              w_gt;
  logic              w_take;
  logic [DATA_W-1:0] w_cand_val;
  logic [IDX_W-1:0]  w_cand_idx;

  assign w_in_shift     = (r_state == c_shift);
  assign w_last         = (r_cnt == c_last);
  assign w_accept       = in_valid[0] & (~w_in_shift | w_last);
  assign w_drop         = in_valid[0] & w_in_shift & ~w_last;
  assign w_mismatch_set = (in_valid != '0) && (in_valid != '1);
  assign w_word         = r_buf[r_cnt];

  generate
    if (SIGNED) begin : g_signed_cmp
      assign w_gt = $signed(w_word) > $signed(r_run_val);
    end else begin : g_unsigned_cmp
      assign w_gt = w_word > r_run_val;
    end
  endgenerate

  // Word 0 always seeds the max; later words replace only when strictly greater.
  assign w_take     = (r_cnt == '0) | w_gt;
  assign w_cand_val = w_take ? w_word : r_run_val;
  assign w_cand_idx = w_take ? r_cnt  : r_run_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (w_accept) w_state_nxt = c_shift;
      c_shift: if (w_last && !w_accept) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    out_valid = w_in_shift;
    busy      = w_in_shift;
    out_data  = w_in_shift ? w_word : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_NEURON; i++) r_buf[i] <= '0;
      r_cnt      <= '0;
      r_run_val  <= '0;
      r_run_idx  <= '0;
      r_done     <= 1'b0;
      r_max_idx  <= '0;
      r_max_val  <= '0;
      r_overrun  <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < NUM_NEURON; i++) r_buf[i] <= in_data[i*DATA_W +: DATA_W];
      end

      if (w_accept) begin
        r_cnt <= '0;
      end else if (w_in_shift) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end

      if (w_accept) begin
        r_run_val <= '0;
        r_run_idx <= '0;
      end else if (w_in_shift) begin
        r_run_val <= w_cand_val;
        r_run_idx <= w_cand_idx;
      end

      // Final word folds straight into the result, so a back-to-back accept
      // can clear the running max without losing vector A's argmax.
      r_done <= w_in_shift & w_last;
      if (w_in_shift && w_last) begin
        r_max_val <= w_cand_val;
        r_max_idx <= w_cand_idx;
      end

      r_overrun  <= w_drop | (r_overrun & ~clr_err);
      r_mismatch <= w_mismatch_set | (r_mismatch & ~clr_err);
    end
  end

  assign done     = r_done;
  assign max_idx  = r_max_idx;
  assign max_val  = r_max_val;
  assign overrun  = r_overrun;
  assign mismatch = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_layer_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_out_serializer
// Description : Scoreboard bench for layer_out_serializer (signed and unsigned).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_out_serializer;

  logic        clk;
  logic        rst;
  logic [1:0]  in_valid;
  logic [31:0] in_data;
  logic        clr_err;

  logic        out_valid,   out_valid_u;
  logic [15:0] out_data,    out_data_u;
  logic        busy,        busy_u;
  logic        done,        done_u;
  logic [0:0]  max_idx,     max_idx_u;
  logic [15:0] max_val,     max_val_u;
  logic        overrun,     overrun_u;
  logic        mismatch,    mismatch_u;

  layer_out_serializer #(.NUM_NEURON(2), .DATA_W(16), .SIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done),
    .max_idx(max_idx), .max_val(max_val), .overrun(overrun), .mismatch(mismatch)
  );

  layer_out_serializer #(.NUM_NEURON(2), .DATA_W(16), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .out_valid(out_valid_u), .out_data(out_data_u), .busy(busy_u), .done(done_u),
    .max_idx(max_idx_u), .max_val(max_val_u), .overrun(overrun_u), .mismatch(mismatch_u)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [31:0] cyc;
  } word_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [0:0]  s_idx;
    logic [15:0] s_val;
    logic [0:0]  u_idx;
    logic [15:0] u_val;
  } done_t;

  word_t       exp_words[$];
  done_t       exp_done[$];
  logic [31:0] cyc;
  int          n_vec;
  int          n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: sample mid-cycle, compare against the head of each queue.
  always @(negedge clk) begin
    logic  exp_v;
    logic  exp_d;
    word_t w;
    done_t d;
    exp_v = (exp_words.size() > 0) && (exp_words[0].cyc == cyc);
    exp_d = (exp_done.size() > 0)  && (exp_done[0].cyc == cyc);
    check("out_valid",   {31'd0, out_valid},   {31'd0, exp_v});
    check("out_valid_u", {31'd0, out_valid_u}, {31'd0, exp_v});
    check("busy",        {31'd0, busy},        {31'd0, exp_v});
    if (exp_v) begin
      w = exp_words.pop_front();
      check("out_data",   {16'd0, out_data},   {16'd0, w.data});
      check("out_data_u", {16'd0, out_data_u}, {16'd0, w.data});
    end else begin
      check("out_data_idle", {16'd0, out_data}, 32'd0);
    end
    check("done",   {31'd0, done},   {31'd0, exp_d});
    check("done_u", {31'd0, done_u}, {31'd0, exp_d});
    if (exp_d) begin
      d = exp_done.pop_front();
      check("max_idx",   {31'd0, max_idx},   {31'd0, d.s_idx});
      check("max_val",   {16'd0, max_val},   {16'd0, d.s_val});
      check("max_idx_u", {31'd0, max_idx_u}, {31'd0, d.u_idx});
      check("max_val_u", {16'd0, max_val_u}, {16'd0, d.u_val});
    end
  end

  // Drives one cycle of stimulus; entered and left at posedge+1.
  task automatic drive(input logic [1:0] v, input logic [15:0] w0, input logic [15:0] w1,
                       input logic acc, input logic [0:0] s_idx, input logic [15:0] s_val,
                       input logic [0:0] u_idx, input logic [15:0] u_val);
    word_t w;
    done_t d;
    in_valid = v;
    in_data  = {w1, w0};
    if (acc) begin
      w.data = w0; w.cyc = cyc + 1; exp_words.push_back(w);
      w.data = w1; w.cyc = cyc + 2; exp_words.push_back(w);
      d.cyc = cyc + 3; d.s_idx = s_idx; d.s_val = s_val; d.u_idx = u_idx; d.u_val = u_val;
      exp_done.push_back(d);
    end
    @(posedge clk); #1;
    in_valid = 2'b00;
    in_data  = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int budget;
    n_vec    = 0;
    n_err    = 0;
    cyc      = 32'd0;
    rst      = 1'b1;
    in_valid = 2'b00;
    in_data  = 32'd0;
    clr_err  = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_max_val",   {16'd0, max_val},   32'd0);
    check("rst_overrun",   {31'd0, overrun},   32'd0);
    check("rst_mismatch",  {31'd0, mismatch},  32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    idle(1);

    // Basic
    drive(2'b11, 16'h0005, 16'h0010, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0010);
    idle(3);
    // Signed vs unsigned ordering
    drive(2'b11, 16'h0003, 16'hFFF0, 1'b1, 1'b0, 16'h0003, 1'b1, 16'hFFF0);
    idle(3);
    // Ties keep lowest index; negatives
    drive(2'b11, 16'h0007, 16'h0007, 1'b1, 1'b0, 16'h0007, 1'b0, 16'h0007);
    idle(3);
    drive(2'b11, 16'h8000, 16'h8001, 1'b1, 1'b1, 16'h8001, 1'b1, 16'h8001);
    idle(3);
    // Back-to-back at cnt==N-1
    drive(2'b11, 16'h0001, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0002);
    idle(1);
    drive(2'b11, 16'h0009, 16'h0004, 1'b1, 1'b0, 16'h0009, 1'b0, 16'h0009);
    idle(4);
    check("overrun_b2b", {31'd0, overrun}, 32'd0);
    // Overrun: second vector one cycle too early
    drive(2'b11, 16'h0020, 16'h0011, 1'b1, 1'b0, 16'h0020, 1'b0, 16'h0020);
    drive(2'b11, 16'h7777, 16'h7777, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    idle(3);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("overrun_clr", {31'd0, overrun}, 32'd0);
    // Mismatch: 01 accepted, 10 ignored
    drive(2'b01, 16'h0100, 16'h0200, 1'b1, 1'b1, 16'h0200, 1'b1, 16'h0200);
    check("mismatch_01", {31'd0, mismatch}, 32'd1);
    idle(3);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("mismatch_clr", {31'd0, mismatch}, 32'd0);
    drive(2'b10, 16'h0AAA, 16'h0BBB, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    check("mismatch_10", {31'd0, mismatch}, 32'd1);
    idle(3);
    check("max_val_held", {16'd0, max_val}, 32'h0000_0200);
    // Asynchronous reset mid-stream: no done for the aborted vector
    drive(2'b11, 16'h0005, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    #1;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_data",  {16'd0, out_data},  32'h0000_0005);
    rst = 1'b0;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_data",  {16'd0, out_data},  32'd0);
    check("abort_busy",  {31'd0, busy},      32'd0);
    check("abort_mism",  {31'd0, mismatch},  32'd0);
    check("abort_maxv",  {16'd0, max_val},   32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    drive(2'b11, 16'h0005, 16'h0010, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0010);

    budget = 0;
    while ((exp_words.size() > 0 || exp_done.size() > 0) && budget < 50) begin
      idle(1);
      budget++;
    end
    n_vec++;
    if (exp_words.size() > 0 || exp_done.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d words %0d dones outstanding, required 0",
               exp_words.size(), exp_done.size());
    end
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
